sr_bank_scheduler: RTL and testbench

- Shares one bank of NFLAG enable-strobed SR latches (status/flag register) between NREQ requesters.
- Round-robin arbitration picks one set/clear request at a time.
- Sequences the latch pins as setup → EN pulse → hold, so S/R are stable around the EN edge and S=R=1 is never driven.
- Sits between the requesting control blocks and the latch bank. Returns a one-cycle ack, or err for an illegal index.

---
 rtl/sr_sched_pkg.sv | 13 +
 rtl/sr_bank_scheduler_rr_arbiter.sv | 22 ++
 rtl/sr_bank_scheduler.sv | 111 +++++++++++
 tb/tb_sr_bank_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_sched_pkg.sv
// sr_sched_pkg: shared types, op encodings and width helper for the SR bank scheduler
package sr_sched_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DONE} state_t;

   localparam logic OP_SET = 1'b1;
   localparam logic OP_CLR = 1'b0;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sr_bank_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr
module rr_arbiter
   import sr_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = clog2_min1(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          valid
);

   // scan from the far end back to ptr so the closest set bit is the last one written
   always_comb begin
      grant = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % N]) grant = PW'((int'(ptr) + i) % N);
      valid = |req;
   end

endmodule

// File: rtl/sr_bank_scheduler.sv
// sr_bank_scheduler: round-robin sharing of an enable-strobed SR latch bank with setup/pulse/hold sequencing
module sr_bank_scheduler
   import sr_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int FW    = $clog2(NFLAG)
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ-1:0]             req_op,
   input  logic [NREQ*FW-1:0]          req_idx,
   output logic [NREQ-1:0]             ack,
   output logic [NREQ-1:0]             err,
   output logic [NFLAG-1:0]            S,
   output logic [NFLAG-1:0]            R,
   output logic [NFLAG-1:0]            EN,
   output logic                        busy,
   output logic [clog2_min1(NREQ)-1:0] grant_id
);

   localparam int GW = clog2_min1(NREQ);

   state_t           state, state_nx;
   logic [GW-1:0]    ptr, gnt, gid_nx;
   logic             valid, take, legal, op_in, g_op, op_nx, g_bad, bad_nx;
   logic [FW-1:0]    idx_in, g_idx, idx_nx;
   logic [NFLAG-1:0] sel, s_nx, r_nx, en_nx;
   logic [NREQ-1:0]  ack_nx, err_nx;

   rr_arbiter #(.N(NREQ), .PW(GW)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (gnt),
      .valid (valid)
   );

   assign take   = (state == IDLE) && valid;
   assign idx_in = req_idx[int'(gnt)*FW +: FW];
   assign op_in  = req_op[gnt];
   assign legal  = int'(idx_in) < NFLAG;
   assign gid_nx = take ? gnt : grant_id;
   assign op_nx  = take ? op_in : g_op;
   assign idx_nx = take ? idx_in : g_idx;
   assign bad_nx = take ? !legal : g_bad;
   assign busy   = state != IDLE;

   // state register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_nx;
   end

   // next state: fixed setup/pulse/hold/done walk, bad index skips straight to done
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = valid ? (legal ? SETUP : DONE) : IDLE;
         SETUP:   state_nx = PULSE;
         PULSE:   state_nx = HOLD;
         HOLD:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   // capture winner's request and advance the round-robin pointer past it
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         grant_id <= '0;
         ptr      <= '0;
         g_op     <= OP_CLR;
         g_idx    <= '0;
         g_bad    <= 1'b0;
      end else if (take) begin
         grant_id <= gnt;
         ptr      <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
         g_op     <= op_in;
         g_idx    <= idx_in;
         g_bad    <= !legal;
      end
   end

   // decode pin values for the state being entered so the pins come straight from flops
   always_comb begin
      sel    = NFLAG'(1) << idx_nx;
      s_nx   = (state_nx inside {SETUP, PULSE, HOLD}) && op_nx == OP_SET ? sel : '0;
      r_nx   = (state_nx inside {SETUP, PULSE, HOLD}) && op_nx == OP_CLR ? sel : '0;
      en_nx  = state_nx == PULSE ? sel : '0;
      ack_nx = (state_nx == DONE && !bad_nx) ? NREQ'(1) << gid_nx : '0;
      err_nx = (state_nx == DONE && bad_nx) ? NREQ'(1) << gid_nx : '0;
   end

   // output register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         S   <= '0;
         R   <= '0;
         EN  <= '0;
         ack <= '0;
         err <= '0;
      end else begin
         S   <= s_nx;
         R   <= r_nx;
         EN  <= en_nx;
         ack <= ack_nx;
         err <= err_nx;
      end
   end

endmodule

// File: tb/tb_sr_bank_scheduler.sv
// tb_sr_bank_scheduler: directed table, corner sequences and model-checked random run
module tb_sr_bank_scheduler;

   localparam int NREQ  = 4;
   localparam int NFLAG = 6;
   localparam int FW    = 3;
   localparam int GW    = 2;

   typedef struct packed {
      logic [NFLAG-1:0] s;
      logic [NFLAG-1:0] r;
      logic [NFLAG-1:0] en;
      logic [NREQ-1:0]  ack;
      logic [NREQ-1:0]  err;
      logic             busy;
      logic [GW-1:0]    gid;
   } rec_t;

   typedef struct {
      logic [NREQ-1:0]    req;
      logic [NREQ-1:0]    op;
      logic [NREQ*FW-1:0] idx;
      rec_t               exp;
   } vec_t;

   logic                CLK = 1'b0;
   logic                RESET = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ-1:0]     req_op = '0;
   logic [NREQ*FW-1:0]  req_idx = '0;
   logic [NREQ-1:0]     ack, err;
   logic [NFLAG-1:0]    S, R, EN;
   logic                busy;
   logic [GW-1:0]       grant_id;
   logic [NFLAG-1:0]    q_lat = '0;

   int tests = 0;
   int fails = 0;

   rec_t             q[$];
   rec_t             cur;
   int               mptr;
   logic [GW-1:0]    mgid;
   int               pend_idx;
   logic             pend_op;
   logic [NFLAG-1:0] mflags;
   vec_t             tbl[12];

   sr_bank_scheduler #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .req      (req),
      .req_op   (req_op),
      .req_idx  (req_idx),
      .ack      (ack),
      .err      (err),
      .S        (S),
      .R        (R),
      .EN       (EN),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 CLK = ~CLK;

   // behavioural latch bank hanging off the pins
   always @(S or R or EN)
      for (int k = 0; k < NFLAG; k++)
         if (EN[k]) q_lat[k] <= S[k] ? 1'b1 : (R[k] ? 1'b0 : q_lat[k]);

   function automatic rec_t mkr(input logic [NFLAG-1:0] s, input logic [NFLAG-1:0] r,
                                input logic [NFLAG-1:0] en, input logic [NREQ-1:0] a,
                                input logic [NREQ-1:0] e, input logic b, input logic [GW-1:0] g);
      rec_t x;
      x.s = s; x.r = r; x.en = en; x.ack = a; x.err = e; x.busy = b; x.gid = g;
      return x;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic cmp(input string nm, input rec_t e);
      rec_t a;
      a = {S, R, EN, ack, err, busy, grant_id};
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got S=%b R=%b EN=%b ack=%b err=%b busy=%b gid=%0d, want S=%b R=%b EN=%b ack=%b err=%b busy=%b gid=%0d",
                  nm, a.s, a.r, a.en, a.ack, a.err, a.busy, a.gid, e.s, e.r, e.en, e.ack, e.err, e.busy, e.gid);
      end
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge CLK);
      RESET = 1'b1;
      req = '0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
   endtask

   // transaction-level model: at each edge, an idle scheduler turns the winning request into its pin timeline
   task automatic model_edge();
      int w;
      logic [FW-1:0] ix;
      logic [NFLAG-1:0] sel;
      rec_t x;
      w = -1;
      if (!cur.busy && q.size() == 0 && req != '0) begin
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && req[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
         mptr = (w + 1) % NREQ;
         mgid = GW'(w);
         ix = req_idx[w*FW +: FW];
         if (int'(ix) >= NFLAG) q.push_back(mkr('0, '0, '0, '0, NREQ'(1) << w, 1'b1, mgid));
         else begin
            sel = NFLAG'(1) << ix;
            pend_idx = int'(ix);
            pend_op = req_op[w];
            x = mkr(pend_op ? sel : '0, pend_op ? '0 : sel, '0, '0, '0, 1'b1, mgid);
            q.push_back(x);
            x.en = sel;
            q.push_back(x);
            x.en = '0;
            q.push_back(x);
            q.push_back(mkr('0, '0, '0, NREQ'(1) << w, '0, 1'b1, mgid));
         end
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = mkr('0, '0, '0, '0, '0, 1'b0, mgid);
      if (cur.ack != '0) mflags[pend_idx] = pend_op;
   endtask

   task automatic rand_cycle(input bit drive);
      model_edge();
      step();
      cmp("random", cur);
      tests++;
      if ((S & R) != '0 || $countones(EN) > 1 || (ack & err) != '0) begin
         fails++;
         $display("FAIL invariant: got S=%b R=%b EN=%b ack=%b err=%b, want no S&R, at most one EN, no ack&err", S, R, EN, ack, err);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!drive || cur.ack[i] || cur.err[i]) req[i] = 1'b0;
         else if (!req[i]) begin
            if ($urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_op[i] = 1'($urandom);
               req_idx[i*FW +: FW] = FW'($urandom_range(0, 7));
            end
         end else if ($urandom_range(0, 15) == 0) req_idx[i*FW +: FW] = FW'($urandom_range(0, 7));
         else if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
      end
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 4'b0001, 12'h003, mkr(6'h08, '0, '0, '0, '0, 1'b1, 2'd0)};
      tbl[1]  = '{4'b0000, 4'b0001, 12'h003, mkr(6'h08, '0, 6'h08, '0, '0, 1'b1, 2'd0)};
      tbl[2]  = '{4'b0000, 4'b0001, 12'h003, mkr(6'h08, '0, '0, '0, '0, 1'b1, 2'd0)};
      tbl[3]  = '{4'b0000, 4'b0001, 12'h003, mkr('0, '0, '0, 4'b0001, '0, 1'b1, 2'd0)};
      tbl[4]  = '{4'b0000, 4'b0001, 12'h003, mkr('0, '0, '0, '0, '0, 1'b0, 2'd0)};
      tbl[5]  = '{4'b0010, 4'b0000, 12'h038, mkr('0, '0, '0, '0, 4'b0010, 1'b1, 2'd1)};
      tbl[6]  = '{4'b0000, 4'b0000, 12'h038, mkr('0, '0, '0, '0, '0, 1'b0, 2'd1)};
      tbl[7]  = '{4'b1111, 4'b0000, 12'h040, mkr('0, 6'h02, '0, '0, '0, 1'b1, 2'd2)};
      tbl[8]  = '{4'b0000, 4'b0000, 12'h040, mkr('0, 6'h02, 6'h02, '0, '0, 1'b1, 2'd2)};
      tbl[9]  = '{4'b0000, 4'b0000, 12'h040, mkr('0, 6'h02, '0, '0, '0, 1'b1, 2'd2)};
      tbl[10] = '{4'b0000, 4'b0000, 12'h040, mkr('0, '0, '0, 4'b0100, '0, 1'b1, 2'd2)};
      tbl[11] = '{4'b0000, 4'b0000, 12'h040, mkr('0, '0, '0, '0, '0, 1'b0, 2'd2)};

      #7;
      cmp("reset_state", mkr('0, '0, '0, '0, '0, 1'b0, 2'd0));
      reset_dut();

      for (int v = 0; v < 12; v++) begin
         req = tbl[v].req;
         req_op = tbl[v].op;
         req_idx = tbl[v].idx;
         step();
         cmp($sformatf("table_%0d", v), tbl[v].exp);
         if (v == 4) chk("latch_q3_set", int'(q_lat[3]), 1);
      end

      reset_dut();
      req_op = 4'b1111;
      req_idx = 12'h688;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step();
         cmp($sformatf("rr_grant_%0d", g), mkr(NFLAG'(1) << (g % 4), '0, '0, '0, '0, 1'b1, GW'(g % 4)));
         repeat (3) step();
         chk($sformatf("rr_ack_%0d", g), int'(ack), 1 << (g % 4));
         step();
      end
      req = '0;

      req_op = 4'b0001;
      req_idx = 12'h002;
      req = 4'b0001;
      step();
      cmp("midop_setup", mkr(6'h04, '0, '0, '0, '0, 1'b1, 2'd0));
      step();
      cmp("midop_pulse", mkr(6'h04, '0, 6'h04, '0, '0, 1'b1, 2'd0));
      req_idx = 12'h005;
      req = '0;
      step();
      cmp("midop_hold", mkr(6'h04, '0, '0, '0, '0, 1'b1, 2'd0));
      step();
      cmp("midop_ack", mkr('0, '0, '0, 4'b0001, '0, 1'b1, 2'd0));
      step();
      cmp("midop_idle", mkr('0, '0, '0, '0, '0, 1'b0, 2'd0));

      req_op = 4'b0000;
      req_idx = 12'h100;
      req = 4'b0100;
      step();
      cmp("rst_setup", mkr('0, 6'h10, '0, '0, '0, 1'b1, 2'd2));
      step();
      cmp("rst_pulse", mkr('0, 6'h10, 6'h10, '0, '0, 1'b1, 2'd2));
      #2 RESET = 1'b1;
      #1 cmp("rst_async", mkr('0, '0, '0, '0, '0, 1'b0, 2'd0));
      req = '0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      req_op = 4'b1111;
      req_idx = 12'h688;
      req = 4'b1111;
      step();
      cmp("rst_ptr0", mkr(6'h01, '0, '0, '0, '0, 1'b1, 2'd0));
      req = '0;
      repeat (4) step();
      chk("latch_flags_directed", int'(q_lat), 6'b001111);

      reset_dut();
      q.delete();
      cur = mkr('0, '0, '0, '0, '0, 1'b0, 2'd0);
      mptr = 0;
      mgid = '0;
      pend_idx = 0;
      pend_op = 1'b0;
      mflags = 6'b001111;
      for (int c = 0; c < 2000; c++) rand_cycle(1'b1);
      for (int c = 0; c < 8; c++) rand_cycle(1'b0);
      chk("latch_flags_random", int'(q_lat), int'(mflags));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
